// File: rtl/rv32i_mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide share one 64-bit working register and take 32 compute cycles.
module rv32i_mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic            req_in_1_signed_i,
  input  logic            req_in_2_signed_i,
  input  logic [1:0]      req_out_sel_i,
  input  logic [XLEN-1:0] req_in_1_i,
  input  logic [XLEN-1:0] req_in_2_i,
  input  logic            kill_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_result_o
);

  localparam logic [1:0] MD_OP_MUL  = 2'd0;
  localparam logic [1:0] MD_OP_DIV  = 2'd1;
  localparam logic [1:0] MD_OP_REM  = 2'd2;
  localparam logic [1:0] MD_OUT_LO  = 2'd0;
  localparam logic [1:0] MD_OUT_HI  = 2'd1;
  localparam logic [1:0] MD_OUT_REM = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_COMPUTE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        sel_q, sel_d;
  logic              sgn1_q, sgn1_d;
  logic              sgn2_q, sgn2_d;
  logic [XLEN-1:0]   in1_q, in1_d;
  logic [XLEN-1:0]   in2_q, in2_d;
  logic [2*XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              div0_q, div0_d;

  logic              neg1, neg2, is_mul;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  assign neg1   = in1_q[XLEN-1] & sgn1_q;
  assign neg2   = in2_q[XLEN-1] & sgn2_q;
  assign mag1   = neg1 ? (~in1_q + 32'd1) : in1_q;
  assign mag2   = neg2 ? (~in2_q + 32'd1) : in2_q;
  assign is_mul = (op_q == MD_OP_MUL);

  // MUL: work = {partial_hi, multiplier}; add multiplicand on lsb, shift right.
  assign mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
  // DIV: work = {remainder, quotient}; the shifted remainder needs a carry bit.
  assign rem_sh   = work_q[2*XLEN-1:XLEN-1];
  assign div_ge   = (rem_sh >= {1'b0, opnd_q});
  assign div_diff = rem_sh[XLEN-1:0] - opnd_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sel_d     = sel_q;
    sgn1_d    = sgn1_q;
    sgn2_d    = sgn2_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !kill_i) begin
          op_d    = req_op_i;
          sel_d   = req_out_sel_i;
          sgn1_d  = req_in_1_signed_i;
          sgn2_d  = req_in_2_signed_i;
          in1_d   = req_in_1_i;
          in2_d   = req_in_2_i;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          work_d    = is_mul ? {32'd0, mag2} : {32'd0, mag1};
          opnd_d    = is_mul ? mag1 : mag2;
          cnt_d     = 5'd31;
          neg_res_d = neg1 ^ neg2;
          neg_rem_d = neg1;
          div0_d    = (in2_q == 32'd0);
          state_d   = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          if (is_mul)
            work_d = {mul_sum, work_q[XLEN-1:1]};
          else if (div_ge)
            work_d = {div_diff, work_q[XLEN-2:0], 1'b1};
          else
            work_d = {rem_sh[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (kill_i || resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      sel_q     <= '0;
      sgn1_q    <= 1'b0;
      sgn2_q    <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
      work_q    <= '0;
      opnd_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      sgn1_q    <= sgn1_d;
      sgn2_q    <= sgn2_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign prod = neg_res_q ? (~work_q + 64'd1) : work_q;
  assign quot = work_q[XLEN-1:0];
  assign rem  = work_q[2*XLEN-1:XLEN];

  // Result is zero outside DONE and for unsupported op/out_sel pairs.
  always_comb begin
    resp_result_o = '0;
    if (state_q == S_DONE) begin
      case (op_q)
        MD_OP_MUL: begin
          if (sel_q == MD_OUT_LO)      resp_result_o = prod[XLEN-1:0];
          else if (sel_q == MD_OUT_HI) resp_result_o = prod[2*XLEN-1:XLEN];
        end
        MD_OP_DIV: begin
          if (sel_q == MD_OUT_LO)
            resp_result_o = div0_q ? 32'hFFFF_FFFF : (neg_res_q ? (~quot + 32'd1) : quot);
        end
        MD_OP_REM: begin
          if (sel_q == MD_OUT_REM)
            resp_result_o = div0_q ? in1_q : (neg_rem_q ? (~rem + 32'd1) : rem);
        end
        default: resp_result_o = '0;
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_DONE);

endmodule

// File: tb/tb_rv32i_mul_div_unit.sv
// Self-checking bench for rv32i_mul_div_unit: directed vector table, random ops
// against an integer-arithmetic reference, and abort/backpressure sequences.
module tb_rv32i_mul_div_unit;

  logic        clk, reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op, req_out_sel;
  logic        req_in_1_signed, req_in_2_signed;
  logic [31:0] req_in_1, req_in_2;
  logic        kill, resp_valid, resp_ready;
  logic [31:0] resp_result;

  int checks = 0;
  int errors = 0;

  rv32i_mul_div_unit #(.XLEN(32)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_op_i          (req_op),
    .req_in_1_signed_i (req_in_1_signed),
    .req_in_2_signed_i (req_in_2_signed),
    .req_out_sel_i     (req_out_sel),
    .req_in_1_i        (req_in_1),
    .req_in_2_i        (req_in_2),
    .kill_i            (kill),
    .resp_valid_o      (resp_valid),
    .resp_ready_i      (resp_ready),
    .resp_result_o     (resp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        s1;
    logic        s2;
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: widen to 64-bit integers and use the language's own * / %.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic s1, input logic s2,
                                            input logic [1:0] sel, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = s1 ? longint'(signed'(a)) : longint'(a);
    sb = s2 ? longint'(signed'(b)) : longint'(b);
    p  = sa * sb;
    ref_model = 32'd0;
    if (op == 2'd0 && sel == 2'd0) ref_model = p[31:0];
    else if (op == 2'd0 && sel == 2'd1) ref_model = p[63:32];
    else if (op == 2'd1 && sel == 2'd0) begin
      if (b == 32'd0) ref_model = 32'hFFFF_FFFF;
      else begin q = sa / sb; ref_model = q[31:0]; end
    end else if (op == 2'd2 && sel == 2'd2) begin
      if (b == 32'd0) ref_model = a;
      else begin r = sa % sb; ref_model = r[31:0]; end
    end
  endfunction

  task automatic start_req(input logic [1:0] op, input logic s1, input logic s2,
                           input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_op = op; req_in_1_signed = s1; req_in_2_signed = s2;
    req_out_sel = sel; req_in_1 = a; req_in_2 = b; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Operands must be ignored after acceptance.
    req_in_1 = $urandom; req_in_2 = $urandom; req_op = 2'($urandom);
    req_out_sel = 2'($urandom);
    req_in_1_signed = 1'($urandom); req_in_2_signed = 1'($urandom);
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic s1, input logic s2,
                        input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    start_req(op, s1, s2, sel, a, b);
    wait_resp(lat);
    res = resp_result;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  vec_t vt[15];
  logic [31:0] res, r0;
  int lat, seen;

  initial begin
    reset = 1'b1; req_valid = 0; req_op = 0; req_in_1_signed = 0; req_in_2_signed = 0;
    req_out_sel = 0; req_in_1 = 0; req_in_2 = 0; kill = 0; resp_ready = 0;

    vt[0]  = '{"mul_lo",     2'd0, 1'b0, 1'b0, 2'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vt[1]  = '{"mulh_ss",    2'd0, 1'b1, 1'b1, 2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vt[2]  = '{"mulhsu",     2'd0, 1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[3]  = '{"mulhu",      2'd0, 1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[4]  = '{"div_s",      2'd1, 1'b1, 1'b1, 2'd0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vt[5]  = '{"rem_s",      2'd2, 1'b1, 1'b1, 2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vt[6]  = '{"divu",       2'd1, 1'b0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF};
    vt[7]  = '{"div_by0",    2'd1, 1'b1, 1'b1, 2'd0, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vt[8]  = '{"rem_by0",    2'd2, 1'b1, 1'b1, 2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    vt[9]  = '{"div_ovf",    2'd1, 1'b1, 1'b1, 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vt[10] = '{"rem_ovf",    2'd2, 1'b1, 1'b1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vt[11] = '{"op3_zero",   2'd3, 1'b0, 1'b0, 2'd0, 32'd5,         32'd3,         32'd0};
    vt[12] = '{"mul_selrem", 2'd0, 1'b0, 1'b0, 2'd2, 32'd5,         32'd3,         32'd0};
    vt[13] = '{"divu_100_7", 2'd1, 1'b0, 1'b0, 2'd0, 32'd100,       32'd7,         32'd14};
    vt[14] = '{"remu_100_7", 2'd2, 1'b0, 1'b0, 2'd2, 32'd100,       32'd7,         32'd2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_result", resp_result, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].op, vt[i].s1, vt[i].s2, vt[i].sel, vt[i].a, vt[i].b, res, lat);
      chk({vt[i].name, "_result"}, res, vt[i].exp);
      chk({vt[i].name, "_latency"}, 32'(lat), 32'd34);
      @(negedge clk);
      chk({vt[i].name, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op, sel;
      logic s1, s2;
      logic [31:0] a, b;
      case ($urandom_range(3))
        0: begin op = 2'd0; sel = 2'd0; end
        1: begin op = 2'd0; sel = 2'd1; end
        2: begin op = 2'd1; sel = 2'd0; end
        default: begin op = 2'd2; sel = 2'd2; end
      endcase
      s1 = 1'($urandom); s2 = 1'($urandom);
      a = $urandom; b = $urandom;
      if ($urandom_range(7) == 0) b = 32'd0;
      if ($urandom_range(7) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if ($urandom_range(3) == 0) b = b >> $urandom_range(31);
      run_op(op, s1, s2, sel, a, b, res, lat);
      chk($sformatf("rand%0d op%0d s%0d%0d a=%h b=%h", i, op, s1, s2, a, b),
          res, ref_model(op, s1, s2, sel, a, b));
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'd34);
    end

    // Backpressure in DONE.
    start_req(2'd0, 1'b1, 1'b1, 2'd0, 32'hFFFF_FFF3, 32'd1234);
    wait_resp(lat);
    r0 = resp_result;
    chk("bp_result", r0, ref_model(2'd0, 1'b1, 1'b1, 2'd0, 32'hFFFF_FFF3, 32'd1234));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp_stable_%0d", i), resp_result, r0);
      chk($sformatf("bp_ready_%0d", i), {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);

    // Kill at COMPUTE cycle 10, then confirm no response appears.
    start_req(2'd1, 1'b0, 1'b0, 2'd0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill_ready", {31'd0, req_ready}, 32'd1);
    chk("kill_valid", {31'd0, resp_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("kill_no_resp", 32'(seen), 32'd0);
    run_op(2'd2, 1'b1, 1'b0, 2'd2, 32'hFFFF_FF00, 32'd7, res, lat);
    chk("after_kill_result", res, ref_model(2'd2, 1'b1, 1'b0, 2'd2, 32'hFFFF_FF00, 32'd7));
    chk("after_kill_latency", 32'(lat), 32'd34);

    // kill in IDLE blocks acceptance.
    @(negedge clk);
    req_op = 2'd0; req_out_sel = 2'd0; req_in_1 = 32'd3; req_in_2 = 32'd4;
    req_valid = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 begin req_valid = 1'b0; kill = 1'b0; end
    @(negedge clk);
    chk("idle_kill_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid || !req_ready) seen++;
    end
    chk("idle_kill_no_accept", 32'(seen), 32'd0);

    // Reset mid-COMPUTE.
    start_req(2'd0, 1'b0, 1'b0, 2'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mid_result", resp_result, 32'd0);
    reset = 1'b0;
    run_op(2'd0, 1'b0, 1'b0, 2'd1, 32'hDEAD_BEEF, 32'h1234_5678, res, lat);
    chk("after_rst_result", res, ref_model(2'd0, 1'b0, 1'b0, 2'd1, 32'hDEAD_BEEF, 32'h1234_5678));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_mul_div_unit.md
Name: rv32i_mul_div_unit

Overview:
- Iterative RV32M multiply/divide responder. It consumes the request bundle (md_req_*) produced by the mul/div control decoder and returns one 32-bit result.
- Sits beside the ALU in the execute stage. The pipeline stalls on req_ready/resp_valid.
- Uses a radix-2 shift-add multiplier and a restoring divider, one bit per cycle, sharing one datapath.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- Op and out-sel encodings come from rv32i_md_constants.vh:
  - MD_OP_WIDTH=2: MD_OP_MUL=0, MD_OP_DIV=1, MD_OP_REM=2.
  - MD_OUT_SEL_WIDTH=2: MD_OUT_LO=0, MD_OUT_HI=1, MD_OUT_REM=2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present (md_req_valid).
- req_ready  out  1  unit can accept a request.
- req_op  in  MD_OP_WIDTH  MUL/DIV/REM.
- req_in_1_signed  in  1  operand 1 is two's complement.
- req_in_2_signed  in  1  operand 2 is two's complement.
- req_out_sel  in  MD_OUT_SEL_WIDTH  LO/HI/REM selection.
- req_in_1  in  32  operand 1 (multiplicand/dividend).
- req_in_2  in  32  operand 2 (multiplier/divisor).
- kill  in  1  pipeline flush; abort any operation in flight.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_result  out  32  final result.

Behaviour:
- Reset:
  - state=IDLE, counter=0, all datapath registers 0.
  - req_ready=1, resp_valid=0, resp_result=0.
  - Reset overrides every other input, including mid-operation.
- States: IDLE, SETUP, COMPUTE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, out_sel, signed flags and both operands, then go to SETUP.
- Signs and magnitudes:
  - Operand sign = msb AND its signed flag.
  - Magnitude = two's-complement negation if the operand is negative, else the raw value.
- SETUP (1 cycle):
  - Load magnitudes into the working registers; counter=31.
  - Record neg_res = sign1 XOR sign2, neg_rem = sign1, div0 = (req_in_2 == 0).
- COMPUTE (32 cycles, counter 31..0):
  - MUL: 64-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1, then shift.
  - DIV/REM: shift the 64-bit remainder/quotient left by 1; subtract the divisor if no borrow and set the quotient bit.
  - Go to DONE when counter==0.
- DONE:
  - resp_valid=1.
  - resp_result is held stable until the cycle where resp_ready=1; the unit then returns to IDLE.
- Result formation (combinational from registers in DONE):
  - MUL: P = neg_res ? -prod64 : prod64. LO returns P[31:0]; HI returns P[63:32].
  - DIV: neg_res ? -quot : quot.
  - REM: neg_rem ? -rem : rem.
  - Any other op/out_sel combination, or op=3: result 0.
- Divide by zero (div0=1):
  - DIV returns 0xFFFFFFFF regardless of signs.
  - REM returns the original req_in_1.
  - Latency is the same as a normal divide.
- Signed overflow: 0x80000000 / 0xFFFFFFFF (both signed) gives quotient 0x80000000 and remainder 0. This falls out of the datapath; no special case.
- Latency:
  - Request accepted in cycle T (IDLE & req_valid); SETUP at T+1; COMPUTE T+2..T+33; resp_valid first high at T+34.
  - req_ready is 0 from T+1 until the cycle after the response handshake.
  - No back-to-back overlap: a new request can be accepted at the earliest in the cycle after resp_valid & resp_ready.
- kill:
  - Asserted in SETUP, COMPUTE or DONE: the next state is IDLE and no response is produced.
  - Asserted in DONE together with resp_ready: kill wins and the response counts as discarded.
  - Ignored in IDLE; a req_valid in the same cycle is not accepted.
- Operand inputs are only sampled at acceptance; later changes have no effect.

Test Plan:
- MUL LO: in1=7, in2=-3 (0xFFFFFFFD), unsigned flags -> resp_result=0xFFFFFFEB, resp_valid first high exactly 34 cycles after acceptance.
- MULH signed: 0x80000000 * 0x80000000 -> 0x40000000; MULHSU: in1=-1 (signed), in2=0xFFFFFFFF (unsigned) -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE.
- DIV/REM signed: -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); DIVU 0xFFFFFFFF / 2 -> 0x7FFFFFFF.
- Corner cases:
  - DIV 5 / 0 -> 0xFFFFFFFF.
  - REM -5 / 0 -> 0xFFFFFFFB.
  - DIV signed 0x80000000 / -1 -> 0x80000000; REM of the same operands -> 0.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_result remain stable and req_ready stays 0; release -> IDLE next cycle.
- Abort cases:
  - kill at COMPUTE cycle 10 -> IDLE next cycle, no resp_valid; the following request returns the correct result.
  - reset asserted mid-COMPUTE -> all outputs at reset values next cycle.
